dmem_responder: RTL

Memory-side responder for the pipeline's data-memory port. Accepts one load/store request at a time over a valid/grant handshake, performs it against on-chip word storage with byte-enable writes, and returns a one-cycle response after a fixed, parameterised latency. It sits between the MEM stage's request logic and the storage array, replacing the zero-latency combinational data memory.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Also holds the error-condition helper, which only matters when DMEM_RESP_ERR_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Misaligned byte address, or a word index beyond the populated storage.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requester (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [31:0]       addr_i;
    logic [WORD_W-1:0] wdata_i;
    logic [BE_W-1:0]   be_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [WORD_W-1:0] rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: byte-enable synchronous write, registered synchronous read, no reset.
// Built as one byte-wide memory per lane so each lane maps onto its own block RAM.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk_i) begin
                if (wr_en && wr_be[gi]) begin
                    mem[wr_idx] <= wr_data[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_reg <= mem[rd_idx];
                end
            end

            assign rd_data[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed LATENCY from accept edge to a one-cycle response.
// Define DMEM_RESP_ERR_EN to flag misaligned / out-of-range accesses; otherwise addresses wrap modulo DEPTH.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              rsel_reg, rsel_next;

    logic              accept;
    logic              acc_err;
    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] mem_rdata;

    assign bus.gnt_o = (state_reg == IDLE);
    // The storage has no reset, so keep it from committing on an edge where reset is held.
    assign accept    = bus.req_i && bus.gnt_o && rst_n_i;
    assign word_idx  = bus.addr_i[IDX_W+1:2];

`ifdef DMEM_RESP_ERR_EN
    assign acc_err = addr_err(bus.addr_i, DEPTH);
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .wr_en   (accept && bus.we_i && !acc_err),
        .wr_idx  (word_idx),
        .wr_data (bus.wdata_i),
        .wr_be   (bus.be_i),
        .rd_en   (accept && !bus.we_i && !acc_err),
        .rd_idx  (word_idx),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            rsel_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            rsel_reg  <= rsel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        rsel_next  = rsel_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    err_next  = acc_err;
                    // Stores and errored accesses present zero data.
                    rsel_next = !bus.we_i && !acc_err;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The array read register only moves on a load accept, so this mux holds between responses.
    assign bus.rdata_o  = rsel_reg ? mem_rdata : '0;
    assign bus.err_o    = err_reg;
    assign bus.rvalid_o = (state_reg == RESP);

endmodule
